code_serializer: RTL and testbench
==================================

Name: code_serializer

Overview:
- Transmit-side counterpart of the team's 4-bit code comparator.
- Accepts a parallel code word over a valid/ready handshake and shifts it out as a framed serial bitstream: start bit, data bits MSB first, optional even-parity bit, stop bit.
- The far end deserialises the stream and compares the recovered word against its stored code.
- Sits between the code source (keypad/register) and the serial link.

Parameters:
- WIDTH, 4, code word width in bits (legal range 2..16).
- CLKS_PER_BIT, 4, clock cycles per serial bit (legal range 1..1024).
- PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- code_in  input  WIDTH  code word to send; sampled only on handshake.
- code_valid  input  1  source has a word on code_in.
- code_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset (async, rst_n low): state=IDLE, tx_out=1, busy=0, done=0, code_ready=1, shift register=0, bit and cycle counters=0. Takes effect immediately, including mid-frame; no partial frame resumes after reset release.
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- code_ready = (state==IDLE), decoded from registered state only. code_ready never depends combinationally on code_valid.
- Handshake:
  - The word is accepted on the rising edge where code_valid && code_ready.
  - code_in is latched into the shift register.
  - Parity is computed as the XOR of all bits of code_in and latched at the same edge.
  - code_valid without code_ready: no effect; the source holds its word.
- States:
  - IDLE: tx_out=1. Goes to START on accept.
  - START: tx_out=0 for CLKS_PER_BIT cycles.
  - DATA: WIDTH bits, MSB first, each held CLKS_PER_BIT cycles.
  - PARITY: entered only if PARITY_EN=1; tx_out=latched parity for CLKS_PER_BIT cycles.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then returns to IDLE.
- Bit timing:
  - Cycle counter runs 0..CLKS_PER_BIT-1.
  - The bit advances when the counter reaches CLKS_PER_BIT-1.
  - The bit counter indexes DATA bits 0..WIDTH-1 and wraps to 0 on leaving DATA.
- Latency: tx_out drops to 0 on the cycle after the accept edge.
- Frame length: (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles.
- busy: 1 in every state except IDLE.
- done: asserted during the last cycle of STOP (counter = CLKS_PER_BIT-1); low otherwise.
- Back-to-back: after STOP the block spends exactly one cycle in IDLE (code_ready=1). A word accepted there starts its start bit on the next cycle. The minimum idle gap between frames is one cycle of tx_out=1.
- code_in changes while busy are ignored; the latched word is transmitted unchanged.
- Registered outputs: tx_out, busy and done are registered, so there is no glitching on tx_out.
- CLKS_PER_BIT=1: every state lasts one cycle; behaviour is otherwise identical.

Decomposition:
- Shared package/include:
  - state encoding localparams: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP (3-bit);
  - default CODE_WIDTH=4;
  - line idle level constant (1'b1).
- Sub-module bit_timer: parameter CLKS_PER_BIT; inputs clk, rst_n, clear, enable; output tick, one cycle at count CLKS_PER_BIT-1. The FSM uses tick to advance. The same timer is reused by the matching deserialiser.

Test Plan:
- Basic frame, CLKS_PER_BIT=4, PARITY_EN=1: code_in=4'b1101 with code_valid for one cycle.
  - Required tx_out, each level held 4 cycles: 0,1,1,0,1,1(parity),1(stop).
  - Total 28 cycles; done high only on cycle 28; busy high on cycles 1-28.
- Parity values:
  - send 4'b1011 -> parity bit 1;
  - send 4'b1001 -> parity 0;
  - send 4'b0000 -> parity 0 and data bits all 0.
- Back-to-back: hold code_valid=1 and present 1101 then 1011.
  - Second accept occurs exactly one cycle after done.
  - tx_out is 1 for exactly one cycle between the two frames.
  - Second frame is 0,1,0,1,1,1,1.
- Hold and ignore: assert code_valid mid-frame with code_in=4'b0110.
  - code_ready stays 0; the current frame is unaffected.
  - 0110 is accepted only in the following IDLE cycle.
- Reset mid-frame: pull rst_n low during DATA bit 2.
  - tx_out=1, busy=0, code_ready=1 immediately, without waiting for a clock edge.
  - After release, a new word 4'b1001 is sent as a clean full frame.
- PARITY_EN=0, CLKS_PER_BIT=1: send 4'b1101.
  - tx_out per cycle: 0,1,1,0,1,1.
  - Frame length is 6 cycles; done is on cycle 6.

Source files
------------

// File: rtl/code_serializer_pkg.sv
// Shared definitions for the code serializer and its matching deserialiser.
package code_serializer_pkg;

   // Frame state encoding
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // Default code word width
   localparam int CODE_WIDTH = 4;

   // Serial line level when nothing is being sent
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/code_serializer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// tick_next is the same flag one cycle early, so a client can register outputs
// that line up with the bit boundary instead of trailing it.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick,
   output logic tick_next
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt, cnt_nxt;

   // Next count: clear wins, otherwise wrap at the end of the bit period
   always_comb begin
      cnt_nxt = cnt;
      if (clear)
         cnt_nxt = '0;
      else if (enable)
         cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end

   assign tick      = (cnt == LAST);
   assign tick_next = (cnt_nxt == LAST);

endmodule

// File: rtl/code_serializer.sv
// Serialises a parallel code word into a framed bitstream:
// start(0), data MSB first, optional even parity, stop(1).
// tx_out/busy/done are registered from the next-state values so they change
// exactly with the state and never glitch.
module code_serializer
   import code_serializer_pkg::*;
#(
   parameter int WIDTH        = CODE_WIDTH,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] code_in,
   input  logic             code_valid,
   output logic             code_ready,
   output logic             tx_out,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(WIDTH);

   logic [2:0]       state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic             par, par_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic             tick, tick_next;
   logic             accept, last_bit;
   logic             tx_d, busy_d, done_d;

   assign code_ready = (state == S_IDLE);
   assign accept     = code_valid && code_ready;
   assign last_bit   = (bit_cnt == BW'(WIDTH - 1));

   // Timer held at zero in IDLE so the start bit always gets a full period
   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state == S_IDLE),
      .enable    (1'b1),
      .tick      (tick),
      .tick_next (tick_next)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: each non-idle state advances on the bit-period tick
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_START;
         S_START:  if (tick)   state_nxt = S_DATA;
         S_DATA:   if (tick && last_bit)
                      state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (tick)   state_nxt = S_STOP;
         S_STOP:   if (tick)   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath next values: latch word and parity on accept, shift per data bit
   always_comb begin
      shreg_nxt   = shreg;
      par_nxt     = par;
      bit_cnt_nxt = bit_cnt;
      if (accept) begin
         shreg_nxt   = code_in;
         par_nxt     = ^code_in;
         bit_cnt_nxt = '0;
      end else if (state == S_DATA && tick) begin
         shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
         bit_cnt_nxt = last_bit ? '0 : bit_cnt + 1'b1;
      end
   end

   // Output decode from the state/data the block is about to enter
   always_comb begin
      tx_d   = LINE_IDLE;
      busy_d = (state_nxt != S_IDLE);
      done_d = (state_nxt == S_STOP) && tick_next;
      case (state_nxt)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_nxt[WIDTH-1];
         S_PARITY: tx_d = par_nxt;
         default:  tx_d = LINE_IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         par     <= 1'b0;
         bit_cnt <= '0;
      end else begin
         shreg   <= shreg_nxt;
         par     <= par_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // Registered line outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_out <= LINE_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         tx_out <= tx_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

endmodule

// File: tb/tb_code_serializer.sv
// Randomised bench for code_serializer: two instances (CLKS_PER_BIT=4 with parity,
// CLKS_PER_BIT=1 without), each tracked by a frame-level model that expands an
// accepted word into its expected per-cycle line levels.
module tb_code_serializer;

   typedef bit bq_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] code_a = '0, code_b = '0;
   logic       valid_a = 1'b0, valid_b = 1'b0;
   logic       rdy_a, tx_a, busy_a, done_a;
   logic       rdy_b, tx_b, busy_b, done_b;

   int n_chk = 0, n_err = 0, cyc = 0;
   int acc_n_a = 0, acc_cyc_a = 0, done_cyc_a = 0;
   int acc_n_b = 0, acc_cyc_b = 0, done_cyc_b = 0;
   bq_t qa, qb;

   always #5 clk = ~clk;

   code_serializer #(.WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .code_in(code_a), .code_valid(valid_a),
      .code_ready(rdy_a), .tx_out(tx_a), .busy(busy_a), .done(done_a));

   code_serializer #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .code_in(code_b), .code_valid(valid_b),
      .code_ready(rdy_b), .tx_out(tx_b), .busy(busy_b), .done(done_b));

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected line levels of one frame, one entry per clock cycle
   function automatic bq_t frame(logic [3:0] w, int cpb, bit par_en);
      bq_t lv, out;
      int ones = 0;
      lv.push_back(1'b0);
      for (int i = 3; i >= 0; i--) begin
         lv.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (par_en) lv.push_back(bit'(ones % 2));
      lv.push_back(1'b1);
      foreach (lv[i])
         for (int k = 0; k < cpb; k++) out.push_back(lv[i]);
      return out;
   endfunction

   always @(posedge clk) cyc++;

   // Model/monitor for instance A
   always @(negedge clk) begin
      bit idle;
      if (!rst_n) begin
         qa.delete();
         chk("a_rst_tx", tx_a, 1); chk("a_rst_busy", busy_a, 0);
         chk("a_rst_done", done_a, 0); chk("a_rst_rdy", rdy_a, 1);
      end else begin
         idle = (qa.size() == 0);
         chk("a_tx", tx_a, idle ? 1'b1 : qa[0]);
         chk("a_busy", busy_a, !idle);
         chk("a_done", done_a, qa.size() == 1);
         chk("a_rdy", rdy_a, idle);
         if (qa.size() == 1) done_cyc_a = cyc;
         if (!idle) void'(qa.pop_front());
         if (idle && valid_a) begin
            qa = frame(code_a, 4, 1'b1);
            acc_cyc_a = cyc;
            acc_n_a++;
         end
      end
   end

   // Model/monitor for instance B
   always @(negedge clk) begin
      bit idle;
      if (!rst_n) begin
         qb.delete();
         chk("b_rst_tx", tx_b, 1); chk("b_rst_busy", busy_b, 0);
      end else begin
         idle = (qb.size() == 0);
         chk("b_tx", tx_b, idle ? 1'b1 : qb[0]);
         chk("b_busy", busy_b, !idle);
         chk("b_done", done_b, qb.size() == 1);
         chk("b_rdy", rdy_b, idle);
         if (qb.size() == 1) done_cyc_b = cyc;
         if (!idle) void'(qb.pop_front());
         if (idle && valid_b) begin
            qb = frame(code_b, 1, 1'b0);
            acc_cyc_b = cyc;
            acc_n_b++;
         end
      end
   end

   task automatic tick_n(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a word on A until the model sees it accepted; leaves valid low
   task automatic wait_acc_a(int n0);
      int t = 0;
      while (acc_n_a == n0 && t < 200) begin tick_n(1); t++; end
      chk("a_acc_timeout", acc_n_a, n0 + 1);
   endtask

   task automatic send_a(logic [3:0] w);
      int n0 = acc_n_a;
      code_a = w; valid_a = 1'b1;
      wait_acc_a(n0);
      valid_a = 1'b0;
   endtask

   task automatic send_b(logic [3:0] w);
      int n0 = acc_n_b, t = 0;
      code_b = w; valid_b = 1'b1;
      while (acc_n_b == n0 && t < 200) begin tick_n(1); t++; end
      chk("b_acc_timeout", acc_n_b, n0 + 1);
      valid_b = 1'b0;
   endtask

   task automatic wait_idle(int limit);
      int t = 0;
      while ((qa.size() != 0 || qb.size() != 0) && t < limit) begin tick_n(1); t++; end
      chk("idle_timeout", (qa.size() != 0 || qb.size() != 0), 0);
      tick_n(1);
   endtask

   initial begin
      int n0;
      tick_n(2);
      rst_n = 1'b1;
      tick_n(2);

      // Basic frame and length on A
      send_a(4'b1101);
      wait_idle(100);
      chk("a_frame_len", done_cyc_a - acc_cyc_a, 28);

      // Parity values
      send_a(4'b1011); wait_idle(100);
      send_a(4'b1001); wait_idle(100);
      send_a(4'b0000); wait_idle(100);

      // Back-to-back with valid held high
      n0 = acc_n_a;
      code_a = 4'b1101; valid_a = 1'b1;
      wait_acc_a(n0);
      code_a = 4'b1011;
      wait_acc_a(n0 + 1);
      valid_a = 1'b0;
      chk("a_b2b_gap", acc_cyc_a - done_cyc_a, 1);
      wait_idle(100);

      // Valid raised mid-frame is held off until the following idle cycle
      send_a(4'b1101);
      tick_n(8);
      n0 = acc_n_a;
      code_a = 4'b0110; valid_a = 1'b1;
      wait_acc_a(n0);
      valid_a = 1'b0;
      chk("a_hold_gap", acc_cyc_a - done_cyc_a, 1);
      wait_idle(100);

      // Asynchronous reset during the third data bit
      send_a(4'b1101);
      tick_n(13);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_tx", tx_a, 1);
      chk("rst_async_busy", busy_a, 0);
      chk("rst_async_rdy", rdy_a, 1);
      tick_n(2);
      #2 rst_n = 1'b1;
      tick_n(2);
      send_a(4'b1001);
      wait_idle(100);
      chk("a_post_rst_len", done_cyc_a - acc_cyc_a, 28);

      // CLKS_PER_BIT=1, no parity
      send_b(4'b1101);
      wait_idle(50);
      chk("b_frame_len", done_cyc_b - acc_cyc_b, 6);

      // Randomised words and gaps on both instances
      for (int i = 0; i < 20; i++) begin
         send_a(4'($urandom_range(0, 15)));
         tick_n($urandom_range(0, 40));
         send_b(4'($urandom_range(0, 15)));
         if ($urandom_range(0, 1) == 1) code_a = 4'($urandom_range(0, 15));
         wait_idle(200);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
